// File: rtl/baud_gen_frac_pkg.sv
// Shared constants, helpers and divisor presets for the fractional UART baud generator.
package baud_gen_frac_pkg;

  localparam int DEF_INT_W  = 16;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_OSR    = 16;

  // Ceiling log2, usable at elaboration time for port widths.
  function automatic int log2_int(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  typedef struct packed {
    logic [DEF_INT_W-1:0]  div_int;
    logic [DEF_FRAC_W-1:0] div_frac;
  } div_preset_t;

  // 50 MHz / 115200 baud / 16x oversample = 27.127 -> 27 + 2/16
  localparam div_preset_t PRESET_50M_115200 = '{div_int: 16'd27, div_frac: 4'd2};

endpackage

// File: rtl/baud_gen_frac_divider.sv
// Fractional clock divider: shadow divisor registers, period counter and
// first-order fraction accumulator producing the oversample tick.
module baud_gen_frac_divider
  import baud_gen_frac_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic [INT_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_load,
  input  logic              i_resync,
  output logic              o_term,
  output logic              o_os_tick
);

  logic [INT_W-1:0]  div_int_q, div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic [INT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              os_tick_q, os_tick_d;

  logic [FRAC_W:0]   acc_sum;
  logic [INT_W-1:0]  term_val;
  logic              restart;
  logic              div_off;
  logic              term_hit;

  // The carry out of the accumulator stretches this period by one cycle.
  assign acc_sum  = {1'b0, acc_q} + {1'b0, div_frac_q};
  assign term_val = div_int_q - INT_W'(1) + INT_W'(acc_sum[FRAC_W]);
  assign restart  = i_div_load | i_resync;
  assign div_off  = (div_int_q == '0);
  assign term_hit = i_en & ~restart & ~div_off & (cnt_q == term_val);

  always_comb begin
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    os_tick_d  = 1'b0;
    if (restart) begin
      cnt_d = '0;
      acc_d = '0;
      if (i_div_load) begin
        div_int_d  = i_div_int;
        div_frac_d = i_div_frac;
      end
    end else if (i_en) begin
      if (div_off) begin
        cnt_d = '0;
        acc_d = '0;
      end else if (term_hit) begin
        cnt_d     = '0;
        acc_d     = acc_sum[FRAC_W-1:0];
        os_tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + INT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      div_int_q  <= '0;
      div_frac_q <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      os_tick_q  <= 1'b0;
    end else begin
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      os_tick_q  <= os_tick_d;
    end
  end

  assign o_term    = term_hit;
  assign o_os_tick = os_tick_q;

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick from the divider, plus the
// per-bit phase counter with bit-boundary and mid-bit tick decode.
module baud_gen_frac
  import baud_gen_frac_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OSR    = DEF_OSR,
  localparam int OS_W  = log2_int(OSR)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic [INT_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_load,
  input  logic              i_resync,
  output logic              o_os_tick,
  output logic              o_mid_tick,
  output logic              o_bit_tick,
  output logic [OS_W-1:0]   o_os_cnt
);

  logic            term_evt;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic            bit_tick_q, bit_tick_d;
  logic            mid_tick_q, mid_tick_d;

  baud_gen_frac_divider #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_divider (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_en       (i_en),
    .i_div_int  (i_div_int),
    .i_div_frac (i_div_frac),
    .i_div_load (i_div_load),
    .i_resync   (i_resync),
    .o_term     (term_evt),
    .o_os_tick  (o_os_tick)
  );

  // term_evt is already gated by restart, so a restart always wins over a tick.
  always_comb begin
    os_cnt_d   = os_cnt_q;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    if (i_div_load | i_resync) begin
      os_cnt_d = '0;
    end else if (term_evt) begin
      os_cnt_d   = os_cnt_q + OS_W'(1);
      bit_tick_d = (os_cnt_q == OS_W'(OSR - 1));
      mid_tick_d = (os_cnt_q == OS_W'(OSR / 2 - 1));
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      os_cnt_q   <= '0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      os_cnt_q   <= os_cnt_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign o_bit_tick = bit_tick_q;
  assign o_mid_tick = mid_tick_q;
  assign o_os_cnt   = os_cnt_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed self-checking bench for baud_gen_frac (INT_W=16, FRAC_W=4, OSR=16).
module tb_baud_gen_frac;
  import baud_gen_frac_pkg::*;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        load;
  logic        resync;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic [3:0]  os_cnt;

  int total = 0;
  int bad   = 0;

  baud_gen_frac dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_en       (en),
    .i_div_int  (div_int),
    .i_div_frac (div_frac),
    .i_div_load (load),
    .i_resync   (resync),
    .o_os_tick  (os_tick),
    .o_mid_tick (mid_tick),
    .o_bit_tick (bit_tick),
    .o_os_cnt   (os_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a negedge; returns at the negedge right after the capturing edge.
  task automatic load_div(input logic [15:0] di, input logic [3:0] df);
    div_int  = di;
    div_frac = df;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    logic [6:0] got;
    rstn = 1'b0; en = 1'b0; div_int = '0; div_frac = '0; load = 1'b0; resync = 1'b0;
    #3;
    got = {os_tick, mid_tick, bit_tick, os_cnt};
    total++;
    if (got !== 7'b0) begin
      bad++;
      $display("FAIL reset_async got=%b want=%b", got, 7'b0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    got = {os_tick, mid_tick, bit_tick, os_cnt};
    total++;
    if (got !== 7'b0) begin
      bad++;
      $display("FAIL reset_idle got=%b want=%b", got, 7'b0);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_div4;
    logic [6:0] got, exp;
    en = 1'b1;
    load_div(16'd4, 4'd0);
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      got = {os_tick, mid_tick, bit_tick, os_cnt};
      exp = {(i % 4 == 0), (i % 64 == 32), (i % 64 == 0), 4'((i / 4) % 16)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL div4 i=%0d got=%b want=%b", i, got, exp);
      end
    end
    $display("div4: 130 cycles checked");
  endtask

  task automatic test_div1;
    logic [6:0] got, exp;
    en = 1'b1;
    load_div(16'd1, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      got = {os_tick, mid_tick, bit_tick, os_cnt};
      exp = {1'b1, (i == 8), (i == 16), 4'(i % 16)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL div1 i=%0d got=%b want=%b", i, got, exp);
      end
    end
    $display("div1: 20 cycles checked");
  endtask

  task automatic test_frac;
    logic [6:0] got, exp;
    logic [3:0] ecnt;
    logic       eos, ebit, emid;
    int         next_t, k;
    en = 1'b1;
    load_div(PRESET_50M_115200.div_int, PRESET_50M_115200.div_frac);
    // Periods cycle 27 x7 then 28 (accumulator carry on every 8th tick).
    next_t = 27; k = 0; ecnt = 4'd0;
    for (int i = 1; i <= 440; i++) begin
      @(negedge clk);
      eos = (i == next_t); ebit = 1'b0; emid = 1'b0;
      if (eos) begin
        ecnt = ecnt + 4'd1;
        ebit = (ecnt == 4'd0);
        emid = (ecnt == 4'd8);
        k++;
        next_t += ((k % 8) == 7) ? 28 : 27;
      end
      got = {os_tick, mid_tick, bit_tick, os_cnt};
      exp = {eos, emid, ebit, ecnt};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL frac i=%0d got=%b want=%b", i, got, exp);
      end
      if (i == 434) begin
        total++;
        if (bit_tick !== 1'b1) begin
          bad++;
          $display("FAIL frac_434 bit_tick=%b want=1", bit_tick);
        end
      end
    end
    $display("frac 27+2/16: 440 cycles checked");
  endtask

  task automatic test_enable;
    logic [6:0] got, exp;
    en = 1'b1;
    load_div(16'd4, 4'd0);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int i = 3; i <= 14; i++) begin
      @(negedge clk);
      if (i == 12) en = 1'b1;
      got = {os_tick, mid_tick, bit_tick, os_cnt};
      exp = (i == 14) ? 7'b100_0001 : 7'b0;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL enable i=%0d got=%b want=%b", i, got, exp);
      end
    end
    $display("enable: hold and resume checked");
  endtask

  task automatic test_resync;
    logic [6:0] got, exp;
    en = 1'b1;
    load_div(16'd4, 4'd0);
    for (int i = 1; i <= 37; i++) @(negedge clk);
    total++;
    if (os_cnt !== 4'd9) begin
      bad++;
      $display("FAIL resync_pre os_cnt=%0d want=9", os_cnt);
    end
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    got = {os_tick, mid_tick, bit_tick, os_cnt};
    total++;
    if (got !== 7'b0) begin
      bad++;
      $display("FAIL resync_restart got=%b want=%b", got, 7'b0);
    end
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      got = {os_tick, mid_tick, bit_tick, os_cnt};
      exp = {(j % 4 == 0), (j == 32), 1'b0, 4'((j / 4) % 16)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL resync j=%0d got=%b want=%b", j, got, exp);
      end
    end
    $display("resync: phase restart checked");
  endtask

  task automatic test_load_terminal(input logic with_resync);
    logic [6:0] got, exp;
    en = 1'b1;
    load_div(16'd4, 4'd0);
    for (int i = 1; i <= 7; i++) @(negedge clk);
    div_int = 16'd2;
    load    = 1'b1;
    resync  = with_resync;
    @(negedge clk);
    load   = 1'b0;
    resync = 1'b0;
    got = {os_tick, mid_tick, bit_tick, os_cnt};
    total++;
    if (got !== 7'b0) begin
      bad++;
      $display("FAIL load_term_suppress rs=%0d got=%b want=%b", with_resync, got, 7'b0);
    end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      got = {os_tick, mid_tick, bit_tick, os_cnt};
      exp = {(j % 2 == 0), 1'b0, 1'b0, 4'(j / 2)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL load_term rs=%0d j=%0d got=%b want=%b", with_resync, j, got, exp);
      end
    end
    $display("load on terminal (resync=%0d): checked", with_resync);
  endtask

  task automatic test_div0;
    int activity;
    en = 1'b1;
    load_div(16'd0, 4'd5);
    activity = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if ({os_tick, mid_tick, bit_tick, os_cnt} !== 7'b0) activity++;
    end
    total++;
    if (activity != 0) begin
      bad++;
      $display("FAIL div0 active_cycles=%0d want=0", activity);
    end
    $display("div0: 1000 idle cycles checked");
  endtask

  task automatic test_async_reset;
    logic [6:0] got;
    int         activity;
    en = 1'b1;
    load_div(16'd4, 4'd0);
    for (int i = 1; i <= 4; i++) @(negedge clk);
    total++;
    if (os_tick !== 1'b1 || os_cnt !== 4'd1) begin
      bad++;
      $display("FAIL areset_pre os_tick=%b os_cnt=%0d want 1/1", os_tick, os_cnt);
    end
    #2 rstn = 1'b0;
    #1;
    got = {os_tick, mid_tick, bit_tick, os_cnt};
    total++;
    if (got !== 7'b0) begin
      bad++;
      $display("FAIL areset_immediate got=%b want=%b", got, 7'b0);
    end
    @(negedge clk);
    rstn = 1'b1;
    activity = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if ({os_tick, mid_tick, bit_tick, os_cnt} !== 7'b0) activity++;
    end
    total++;
    if (activity != 0) begin
      bad++;
      $display("FAIL areset_shadow_cleared active_cycles=%0d want=0", activity);
    end
    $display("async reset: immediate clear and idle checked");
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div1();
    test_frac();
    test_enable();
    test_resync();
    test_load_terminal(1'b0);
    test_load_terminal(1'b1);
    test_div0();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised successor to the single-divisor UART baud clock generator.
- Produces an oversample tick from a fractional divisor (integer plus fraction, first-order accumulator), then divides by OSR to give a bit tick and a mid-bit tick.
- Supports phase resynchronisation for the UART RX start-bit edge.
- Sits between the UART control registers and the uart_tx/uart_rx engines; one instance per UART channel.

Parameters:
- INT_W, 16, width of the integer divisor.
- FRAC_W, 4, width of the fractional divisor (fraction = i_div_frac / 2^FRAC_W).
- OSR, 16, oversample ticks per bit; power of two, >= 4.

Ports:
- i_clk  input  1  system clock
- i_rstn  input  1  asynchronous active-low reset
- i_en  input  1  generator enable; low freezes all state
- i_div_int  input  INT_W  integer divisor, sampled only on i_div_load
- i_div_frac  input  FRAC_W  fractional divisor, sampled only on i_div_load
- i_div_load  input  1  one-cycle pulse: capture divisor into shadow regs, restart phase
- i_resync  input  1  one-cycle pulse: restart phase, keep divisor
- o_os_tick  output  1  one-cycle oversample tick
- o_mid_tick  output  1  one-cycle tick at bit centre (os_cnt wraps into OSR/2)
- o_bit_tick  output  1  one-cycle tick at bit boundary (os_cnt wraps OSR-1 -> 0)
- o_os_cnt  output  log2(OSR)  current oversample phase within the bit

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rstn.
- Reset values: all outputs 0; cnt=0, acc=0, os_cnt=0; shadow div_int=0 and div_frac=0, so the generator is idle until first load.
- Fractional divider:
  - Each enabled cycle: cnt increments.
  - Terminal value term = div_int - 1 + carry, where carry = MSB of (acc + div_frac), computed FRAC_W+1 wide.
  - At cnt==term: cnt<=0, acc<=(acc+div_frac) mod 2^FRAC_W, o_os_tick<=1 on the next edge. Otherwise o_os_tick<=0.
  - Average oversample period = div_int + div_frac/2^FRAC_W cycles. Each individual period is div_int or div_int+1 cycles.
- Latency: with cnt=0 and i_en high from edge 0, the first o_os_tick is high in the cycle after edge div_int+carry.
- Phase counter:
  - os_cnt increments (mod OSR) on each internal terminal event.
  - o_bit_tick is asserted coincident with o_os_tick when os_cnt wraps OSR-1 -> 0.
  - o_mid_tick is asserted coincident with o_os_tick when os_cnt goes OSR/2-1 -> OSR/2.
  - o_os_cnt is registered and updates in the same cycle as the ticks.
- div_int==0: no ticks at all; cnt, acc and os_cnt held at 0 (divider off).
- div_int==1, frac==0: o_os_tick high every enabled cycle.
- i_en low: cnt, acc and os_cnt hold their values, all ticks 0. Re-enabling resumes mid-period; no phase reset.
- i_div_load (regardless of i_en): shadow<=inputs; cnt, acc and os_cnt<=0; ticks 0 that cycle. New divisor governs from the next cycle.
- i_resync: same restart as load but shadow unchanged.
- Load or resync on a terminal cycle: restart wins and the tick is suppressed.
- Load and resync together: behaves as load.
- Reset mid-operation: immediate return to reset values; shadow divisor lost.

Decomposition:
- Shared uart package holds:
  - default INT_W/FRAC_W/OSR constants;
  - a localparam function for log2(OSR);
  - common divisor presets (e.g. 50 MHz / 115200 / 16 = 27 + 2/16).
- One natural sub-module: frac_divider (shadow regs, cnt, acc, os_tick generation).
- Top level adds the os_cnt phase counter and bit/mid tick decode.

Test Plan:
- Reset, then div_int=4, frac=0 loaded, i_en=1 -> o_os_tick every 4 cycles; o_bit_tick every 64 cycles; o_mid_tick exactly 32 cycles after each o_bit_tick.
- div_int=27, frac=2 (FRAC_W=4) -> over 16 os ticks, 14 periods of 27 cycles and 2 of 28, total 434 cycles; check at every accumulator wrap.
- Drop i_en for 10 cycles mid-period with cnt=2 -> no ticks; counting resumes at cnt=2; next tick delayed by exactly 10 cycles.
- i_resync pulse at os_cnt=9 -> os_cnt=0; first o_os_tick div_int cycles later; o_mid_tick at the 8th os tick after resync.
- i_div_load asserted on a terminal cycle with new div_int=2 -> that tick suppressed; ticks then every 2 cycles; load + resync together give the same result.
- div_int=0 loaded -> no ticks for 1000 cycles, o_os_cnt=0. Then async i_rstn low mid-run -> all outputs 0 immediately and shadow divisor cleared.
